// File: rtl/norm_packer.sv
// norm_packer: receiving end of the normalizer output stream.
//
// Two parallel element streams (core 1 and core 2) arrive one element per
// beat. Each stream is collected into a COL-lane vector. A completed vector
// pair goes into a 2-entry output buffer and is presented downstream over a
// valid/ready handshake. The upstream side has no backpressure: a vector that
// completes while the buffer is full, with no pop on the same edge, is dropped
// and the sticky overflow flag is set.
//
// Optional build macro NORM_PACK_SAT_EN: each element is treated as unsigned
// and clamped to 255 before it is packed. When the macro is undefined,
// elements are stored bit-exact.
//
// Ports:
//   clk          single clock
//   reset        asynchronous, active-high reset
//   norm_valid   beat qualifier for psum_norm_1/psum_norm_2
//   psum_norm_1  core-1 normalized element (W_OUT bits)
//   psum_norm_2  core-2 normalized element (W_OUT bits)
//   flush        discard the partially collected vector
//   m_ready      downstream accepts the head vector
//   m_valid      head vector available
//   m_data_1     core-1 vector; lane i at [i*W_OUT +: W_OUT]
//   m_data_2     core-2 vector; same lane layout
//   busy         partial vector in progress (lane count != 0)
//   overflow     sticky: a completed vector was dropped
module norm_packer #(
  parameter int COL   = 8,
  parameter int W_OUT = 16,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 norm_valid,
  input  logic [W_OUT-1:0]     psum_norm_1,
  input  logic [W_OUT-1:0]     psum_norm_2,
  input  logic                 flush,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic [COL*W_OUT-1:0] m_data_1,
  output logic [COL*W_OUT-1:0] m_data_2,
  output logic                 busy,
  output logic                 overflow
);

  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int VW = COL * W_OUT;

  logic [CW-1:0]    cnt;
  logic [VW-1:0]    pack_1, pack_2;
  logic [VW-1:0]    full_1, full_2;
  logic [VW-1:0]    tail_1, tail_2;
  logic [W_OUT-1:0] el_1, el_2;
  logic [1:0]       occ;
  logic             beat, push, pop, buf_full;

`ifdef NORM_PACK_SAT_EN
  // Normalized full scale is 256, so the value range saturates to 8 bits.
  function automatic logic [W_OUT-1:0] sat8(input logic [W_OUT-1:0] v);
    if (v > W_OUT'(255)) return W_OUT'(255);
    return v;
  endfunction

  assign el_1 = sat8(psum_norm_1);
  assign el_2 = sat8(psum_norm_2);
`else
  assign el_1 = psum_norm_1;
  assign el_2 = psum_norm_2;
`endif

  // Pack registers with the current beat merged into lane cnt. This is both
  // the next pack value and, on the final beat, the completed vector, so the
  // push happens on the same edge as the last beat.
  always_comb begin
    full_1 = pack_1;
    full_2 = pack_2;
    full_1[cnt*W_OUT +: W_OUT] = el_1;
    full_2[cnt*W_OUT +: W_OUT] = el_2;
  end

  // flush wins over a coincident beat, including a would-be final beat.
  assign beat     = norm_valid && !flush;
  assign push     = beat && (cnt == CW'(COL - 1));
  assign pop      = m_valid && m_ready;
  assign buf_full = (occ == 2'(DEPTH));

  assign m_valid  = (occ != 2'd0);
  assign busy     = (cnt != '0);

  // Collect stage: lane counter and pack registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      pack_1 <= '0;
      pack_2 <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (norm_valid) begin
      pack_1 <= full_1;
      pack_2 <= full_2;
      cnt    <= push ? '0 : cnt + CW'(1);
    end
  end

  // Output buffer: m_data_* is the head register itself, tail_* holds the
  // second entry. A pop shifts tail into head, so order is preserved when a
  // push and pop coincide on a full buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= 2'd0;
      m_data_1 <= '0;
      m_data_2 <= '0;
      tail_1   <= '0;
      tail_2   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && buf_full && !pop) overflow <= 1'b1;
      case (occ)
        2'd0: begin
          if (push) begin
            m_data_1 <= full_1;
            m_data_2 <= full_2;
            occ      <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            m_data_1 <= full_1;
            m_data_2 <= full_2;
          end else if (push) begin
            tail_1 <= full_1;
            tail_2 <= full_2;
            occ    <= 2'd2;
          end else if (pop) begin
            occ <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            m_data_1 <= tail_1;
            m_data_2 <= tail_2;
            if (push) begin
              tail_1 <= full_1;
              tail_2 <= full_2;
            end else begin
              occ <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
